// File: rtl/bme280_poll_sequencer.sv
// BME280 bring-up and polling sequencer driving an i2c_master command port.
// Define BME280_SEQ_HUM_EN for humidity config and the 8-byte burst; otherwise BMP280-compatible 6-byte burst.
module bme280_poll_sequencer #(
  parameter logic [6:0] SLAVE_ADDR     = 7'h76,
  parameter logic [7:0] CHIP_ID        = 8'h60,
  parameter logic [7:0] CTRL_MEAS      = 8'h27,
  parameter logic [7:0] CTRL_HUM       = 8'h01,
  parameter int         RESET_WAIT_CYC = 200000,
  parameter int         POLL_CYC       = 10000000,
  parameter int         TIMEOUT_CYC    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        i2c_en,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw,
  output logic [7:0]  i2c_reg_addr,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_done,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic [15:0] hum_raw,
  output logic        sample_valid,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    IDLE, RST_WR, RST_WAIT, ID_RD, HUM_WR, MEAS_WR, BURST_RD, PUBLISH, POLL_WAIT, ERROR
  } state_t;

  localparam int MAX_AB   = (RESET_WAIT_CYC > POLL_CYC) ? RESET_WAIT_CYC : POLL_CYC;
  localparam int MAX_WAIT = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

`ifdef BME280_SEQ_HUM_EN
  localparam int     NBYTES   = 8;
  localparam state_t AFTER_ID = HUM_WR;
`else
  localparam int     NBYTES   = 6;
  localparam state_t AFTER_ID = MEAS_WR;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       rbuf  [NBYTES];
  logic [7:0]       burst [NBYTES];
  logic             is_txn;
  logic             cmd_rw;
  logic [7:0]       cmd_reg;
  logic [7:0]       cmd_wdata;

  assign busy = (state != IDLE) && (state != ERROR);

  // Command fields for whichever transaction state we are in.
  always_comb begin
    is_txn    = 1'b1;
    cmd_rw    = 1'b0;
    cmd_reg   = 8'h00;
    cmd_wdata = 8'h00;
    case (state)
      RST_WR:   begin cmd_reg = 8'hE0; cmd_wdata = 8'hB6; end
      ID_RD:    begin cmd_rw = 1'b1; cmd_reg = 8'hD0; end
      HUM_WR:   begin cmd_reg = 8'hF2; cmd_wdata = CTRL_HUM; end
      MEAS_WR:  begin cmd_reg = 8'hF4; cmd_wdata = CTRL_MEAS; end
      BURST_RD: begin cmd_rw = 1'b1; cmd_reg = 8'hF7 + {5'b0, idx}; end
      default:  is_txn = 1'b0;
    endcase
  end

  // Burst bytes with the byte arriving this cycle merged in, so publish needs no extra cycle.
  always_comb begin
    for (int k = 0; k < NBYTES; k++)
      burst[k] = (idx == 3'(k)) ? i2c_rdata : rbuf[k];
  end

`ifndef BME280_SEQ_HUM_EN
  assign hum_raw = 16'h0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      i2c_en         <= 1'b0;
      i2c_slave_addr <= '0;
      i2c_rw         <= 1'b0;
      i2c_reg_addr   <= '0;
      i2c_wdata      <= '0;
      press_raw      <= '0;
      temp_raw       <= '0;
`ifdef BME280_SEQ_HUM_EN
      hum_raw        <= '0;
`endif
      sample_valid   <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'b00;
      for (int k = 0; k < NBYTES; k++) rbuf[k] <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (is_txn) begin
        // i2c_en doubles as the "transaction pending" flag.
        if (!i2c_en) begin
          cnt <= '0;
          if (!run) begin
            state <= IDLE;
          end else begin
            i2c_en         <= 1'b1;
            i2c_slave_addr <= SLAVE_ADDR;
            i2c_rw         <= cmd_rw;
            i2c_reg_addr   <= cmd_reg;
            i2c_wdata      <= cmd_wdata;
          end
        end else if (i2c_done) begin
          i2c_en <= 1'b0;
          cnt    <= '0;
          if (!run) begin
            state <= IDLE;
          end else begin
            case (state)
              RST_WR: state <= RST_WAIT;
              ID_RD: begin
                if (i2c_rdata != CHIP_ID) begin
                  state    <= ERROR;
                  error    <= 1'b1;
                  err_code <= 2'b01;
                end else begin
                  state <= AFTER_ID;
                end
              end
              HUM_WR: state <= MEAS_WR;
              MEAS_WR: begin
                state <= BURST_RD;
                idx   <= '0;
              end
              BURST_RD: begin
                rbuf[idx] <= i2c_rdata;
                if (idx == LAST_IDX) begin
                  press_raw    <= {burst[0], burst[1], burst[2][7:4]};
                  temp_raw     <= {burst[3], burst[4], burst[5][7:4]};
`ifdef BME280_SEQ_HUM_EN
                  hum_raw      <= {burst[6], burst[7]};
`endif
                  sample_valid <= 1'b1;
                  state        <= PUBLISH;
                end else begin
                  idx <= idx + 3'd1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end else if (cnt == TO_LAST) begin
          i2c_en <= 1'b0;
          cnt    <= '0;
          if (run) begin
            state    <= ERROR;
            error    <= 1'b1;
            err_code <= 2'b10;
          end else begin
            state <= IDLE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (run) state <= RST_WR;
          end
          RST_WAIT: begin
            if (!run) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == RST_LAST) begin
              state <= ID_RD;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PUBLISH: begin
            cnt   <= '0;
            state <= run ? POLL_WAIT : IDLE;
          end
          POLL_WAIT: begin
            if (!run) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == POLL_LAST) begin
              state <= BURST_RD;
              idx   <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ERROR: begin
            cnt <= '0;
            if (!run) begin
              state    <= IDLE;
              error    <= 1'b0;
              err_code <= 2'b00;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
